mcash_ch_arb: RTL and testbench

- Shares the single mcash cache pipeline between request channels ch0/ch1/ch2 using round-robin arbitration.
- Tags each accepted request with its channel ID and records that ID in an in-order tag FIFO.
- Steers each pipeline return back to the channel that issued the matching request.
- Sits between the three channel ports of mcash_top and the pipeline's single request/return port.

---
 rtl/mcash_pkg.sv | 29 ++
 rtl/mcash_ch_arb_if.sv | 36 +++
 rtl/mcash_tag_fifo.sv | 73 +++++++
 rtl/mcash_ch_arb.sv | 119 +++++++++++
 tb/tb_mcash_ch_arb.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcash_pkg.sv
// Shared types for the mcash channel arbiter: channel IDs, op codes and the request payload.
package mcash_pkg;

  localparam int unsigned MCASH_CH_NUM = 3;

  typedef logic [1:0] ch_id_t;

  typedef enum logic [2:0] {
    OpRead     = 3'd0,
    OpWrite    = 3'd1,
    OpFlush    = 3'd2,
    OpInval    = 3'd3,
    OpPrefetch = 3'd4
  } mcash_op_e;

  typedef struct packed {
    mcash_op_e     op;
    logic [31:4]   addr;
    logic [127:0]  data;
  } mcash_req_t;

  // Channel ID arithmetic modulo the channel count.
  function automatic ch_id_t ch_add(input ch_id_t id, input int unsigned inc);
    int unsigned sum;
    sum = (32'(id) + inc) % MCASH_CH_NUM;
    return ch_id_t'(sum);
  endfunction

endpackage

// File: rtl/mcash_ch_arb_if.sv
// Channel-side and pipeline-side handshake bundle of the mcash channel arbiter.
interface mcash_ch_arb_if;
  import mcash_pkg::*;

  logic       [MCASH_CH_NUM-1:0]        ch_req_valid;
  logic       [MCASH_CH_NUM-1:0]        ch_req_allow_in;
  mcash_req_t [MCASH_CH_NUM-1:0]        ch_req;
  logic       [MCASH_CH_NUM-1:0]        ch_rtn_valid;
  logic       [MCASH_CH_NUM-1:0]        ch_rtn_ready;
  logic       [MCASH_CH_NUM-1:0][127:0] ch_rtn_data;

  logic        pipe_req_valid;
  logic        pipe_req_allow_in;
  mcash_req_t  pipe_req;
  ch_id_t      pipe_req_chid;
  logic        pipe_rtn_valid;
  logic        pipe_rtn_ready;
  logic [127:0] pipe_rtn_data;

  // Arbiter side.
  modport slave (
    input  ch_req_valid, ch_req, ch_rtn_ready,
    output ch_req_allow_in, ch_rtn_valid, ch_rtn_data,
    output pipe_req_valid, pipe_req, pipe_req_chid, pipe_rtn_ready,
    input  pipe_req_allow_in, pipe_rtn_valid, pipe_rtn_data
  );

  // Environment side: channels plus pipeline.
  modport master (
    output ch_req_valid, ch_req, ch_rtn_ready,
    input  ch_req_allow_in, ch_rtn_valid, ch_rtn_data,
    input  pipe_req_valid, pipe_req, pipe_req_chid, pipe_rtn_ready,
    output pipe_req_allow_in, pipe_rtn_valid, pipe_rtn_data
  );

endinterface

// File: rtl/mcash_tag_fifo.sv
// In-order tag FIFO with free-running wrap pointers and an occupancy count.
module mcash_tag_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2,
    parameter int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("mcash_tag_fifo: Depth must be a power of 2 and at least 2");
    end

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AddrW-1:0] wptr_q, wptr_d;
    logic [AddrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        push_ok = push_i & ~full_o;
        pop_ok  = pop_i & ~empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mcash_ch_arb.sv
// Round-robin arbiter sharing the mcash pipeline between three channels; returns are
// steered back in order using a FIFO of issuing channel IDs.
module mcash_ch_arb
    import mcash_pkg::*;
#(
    parameter int unsigned OUTSTD = 4,
    parameter int unsigned CNT_W  = $clog2(OUTSTD) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mcash_ch_arb_if.slave     bus,
    output logic [CNT_W-1:0]  outstd_cnt_o,
    output logic              err_o
);

    ch_id_t rr_ptr_q, rr_ptr_d;
    ch_id_t lock_id_q, lock_id_d;
    logic   lock_q, lock_d;
    logic   err_q, err_d;

    ch_id_t gnt;
    ch_id_t head;
    logic   found;
    logic   req_valid, fire;
    logic   fifo_full, fifo_empty;
    logic   head_ready, rtn_pop;

    // First valid channel starting at rr_ptr; a pending lock overrides the search.
    always_comb begin
        gnt   = rr_ptr_q;
        found = 1'b0;
        for (int unsigned k = 0; k < MCASH_CH_NUM; k++) begin
            if (!found && bus.ch_req_valid[ch_add(rr_ptr_q, k)]) begin
                gnt   = ch_add(rr_ptr_q, k);
                found = 1'b1;
            end
        end
        if (lock_q) begin
            gnt = lock_id_q;
        end
    end

    assign req_valid = rst_i & bus.ch_req_valid[gnt] & ~fifo_full;
    assign fire      = req_valid & bus.pipe_req_allow_in;

    assign bus.pipe_req_valid = req_valid;
    assign bus.pipe_req       = bus.ch_req[gnt];
    assign bus.pipe_req_chid  = gnt;

    always_comb begin
        for (int unsigned n = 0; n < MCASH_CH_NUM; n++) begin
            bus.ch_req_allow_in[n] = fire & (gnt == ch_id_t'(n));
            bus.ch_rtn_valid[n]    = rst_i & bus.pipe_rtn_valid & ~fifo_empty &
                                     (head == ch_id_t'(n));
            bus.ch_rtn_data[n]     = bus.pipe_rtn_data;
        end
    end

    always_comb begin
        head_ready = 1'b0;
        unique case (head)
            2'd0:    head_ready = bus.ch_rtn_ready[0];
            2'd1:    head_ready = bus.ch_rtn_ready[1];
            2'd2:    head_ready = bus.ch_rtn_ready[2];
            default: head_ready = 1'b0;
        endcase
    end

    // An empty FIFO swallows any return beat so a stray return cannot wedge the pipeline.
    assign bus.pipe_rtn_ready = rst_i & (fifo_empty | head_ready);
    assign rtn_pop            = bus.pipe_rtn_valid & bus.pipe_rtn_ready & ~fifo_empty;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q | (bus.pipe_rtn_valid & fifo_empty);
        if (fire) begin
            rr_ptr_d = ch_add(gnt, 1);
            lock_d   = 1'b0;
        end else if (req_valid) begin
            lock_d    = 1'b1;
            lock_id_d = gnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

    mcash_tag_fifo #(
        .Depth (OUTSTD),
        .Width ($bits(ch_id_t)),
        .CntW  (CNT_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fire),
        .wdata_i (gnt),
        .pop_i   (rtn_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstd_cnt_o)
    );

endmodule

// File: tb/tb_mcash_ch_arb.sv
// Directed bench for mcash_ch_arb: arbitration order, lock, FIFO full, in-order returns,
// stray-return error and asynchronous reset.
module tb_mcash_ch_arb;
    import mcash_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] cnt;
    logic       err;
    int         n_chk;
    int         n_pass;
    int         n_fail;

    mcash_ch_arb_if bus ();

    mcash_ch_arb #(
        .OUTSTD (4),
        .CNT_W  (3)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .outstd_cnt_o (cnt),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        clk    = 1'b0;
        rst    = 1'b0;
        bus.ch_req_valid      = 3'b111;
        bus.ch_rtn_ready      = 3'b111;
        bus.pipe_req_allow_in = 1'b1;
        bus.pipe_rtn_valid    = 1'b1;
        bus.pipe_rtn_data     = '0;
        for (int n = 0; n < 3; n++) begin
            bus.ch_req[n].op   = OpWrite;
            bus.ch_req[n].addr = 28'(n + 1);
            bus.ch_req[n].data = 128'(n + 16);
        end
        #2;
        chk("rst_pipe_valid", 128'(bus.pipe_req_valid), 128'd0);
        chk("rst_allow_in", 128'(bus.ch_req_allow_in), 128'd0);
        chk("rst_rtn_valid", 128'(bus.ch_rtn_valid), 128'd0);
        chk("rst_cnt", 128'(cnt), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        bus.pipe_rtn_valid = 1'b0;
        cyc();
        rst = 1'b1;

        // Round robin with all channels valid; each return goes to the oldest issuer.
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            bus.pipe_rtn_valid = (k > 0);
            bus.pipe_rtn_data  = 128'(100 + k);
            #1;
            chk("rr_chid", 128'(bus.pipe_req_chid), 128'(k % 3));
            chk("rr_allow_in", 128'(bus.ch_req_allow_in), 128'(1 << (k % 3)));
            chk("rr_addr", 128'(bus.pipe_req.addr), 128'((k % 3) + 1));
            chk("rr_cnt", 128'(cnt), (k == 0) ? 128'd0 : 128'd1);
            if (k > 0) begin
                chk("rr_rtn_valid", 128'(bus.ch_rtn_valid), 128'(1 << ((k - 1) % 3)));
                chk("rr_rtn_data", bus.ch_rtn_data[(k - 1) % 3], 128'(100 + k));
            end
        end
        cyc();
        bus.ch_req_valid   = 3'b000;
        bus.pipe_rtn_data  = 128'd106;
        #1;
        chk("rr_last_rtn", 128'(bus.ch_rtn_valid), 128'b100);
        cyc();
        bus.pipe_rtn_valid = 1'b0;
        #1;
        chk("rr_drained_cnt", 128'(cnt), 128'd0);

        // Stall on ch1 for three cycles; ch0 arriving mid-stall must not steal the grant.
        bus.ch_req_valid      = 3'b010;
        bus.ch_req[1].addr    = 28'h2;
        bus.pipe_req_allow_in = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) cyc();
            if (s == 1) bus.ch_req_valid = 3'b011;
            bus.pipe_req_allow_in = (s == 3);
            #1;
            chk("lock_valid", 128'(bus.pipe_req_valid), 128'd1);
            chk("lock_chid", 128'(bus.pipe_req_chid), 128'd1);
            chk("lock_addr", 128'(bus.pipe_req.addr), 128'h2);
            chk("lock_allow_in", 128'(bus.ch_req_allow_in), (s == 3) ? 128'b010 : 128'd0);
        end
        cyc();
        bus.ch_req_valid = 3'b001;
        #1;
        chk("post_lock_chid", 128'(bus.pipe_req_chid), 128'd0);
        chk("post_lock_cnt", 128'(cnt), 128'd1);
        cyc();
        bus.ch_req_valid   = 3'b000;
        bus.pipe_rtn_valid = 1'b1;
        bus.pipe_rtn_data  = 128'h11;
        #1;
        chk("lock_rtn_ch1", 128'(bus.ch_rtn_valid), 128'b010);
        chk("lock_rtn_cnt", 128'(cnt), 128'd2);
        cyc();
        #1;
        chk("lock_rtn_ch0", 128'(bus.ch_rtn_valid), 128'b001);
        cyc();
        bus.pipe_rtn_valid = 1'b0;
        #1;
        chk("lock_drained_cnt", 128'(cnt), 128'd0);

        // Fill the tag FIFO from ch2, then check no bypass and no lock while full.
        bus.ch_req_valid      = 3'b100;
        bus.pipe_req_allow_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            #1;
            chk("fill_allow_in", 128'(bus.ch_req_allow_in), 128'b100);
            chk("fill_cnt", 128'(cnt), 128'(i));
        end
        cyc();
        bus.pipe_req_allow_in = 1'b0;
        #1;
        chk("full_blocked", 128'(bus.pipe_req_valid), 128'd0);
        chk("full_cnt", 128'(cnt), 128'd4);
        cyc();
        bus.ch_req_valid      = 3'b101;
        bus.pipe_req_allow_in = 1'b1;
        bus.pipe_rtn_valid    = 1'b1;
        #1;
        chk("full_no_bypass", 128'(bus.pipe_req_valid), 128'd0);
        chk("full_pop_rtn", 128'(bus.ch_rtn_valid), 128'b100);
        chk("full_pop_ready", 128'(bus.pipe_rtn_ready), 128'd1);
        cyc();
        bus.pipe_rtn_valid = 1'b0;
        #1;
        chk("refill_cnt", 128'(cnt), 128'd3);
        chk("refill_chid", 128'(bus.pipe_req_chid), 128'd0);
        chk("refill_allow_in", 128'(bus.ch_req_allow_in), 128'b001);
        cyc();
        bus.ch_req_valid   = 3'b000;
        bus.pipe_rtn_valid = 1'b1;
        #1;
        chk("refill_full_cnt", 128'(cnt), 128'd4);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) cyc();
            #1;
            chk("full_drain_rtn", 128'(bus.ch_rtn_valid), (j < 3) ? 128'b100 : 128'b001);
        end
        cyc();
        bus.pipe_rtn_valid = 1'b0;
        #1;
        chk("full_drained_cnt", 128'(cnt), 128'd0);

        // Head-of-line blocking: ch2 stalls its return, ch0's return must wait.
        bus.ch_req_valid = 3'b100;
        #1;
        chk("hol_issue_ch2", 128'(bus.ch_req_allow_in), 128'b100);
        cyc();
        bus.ch_req_valid = 3'b001;
        #1;
        chk("hol_issue_ch0", 128'(bus.ch_req_allow_in), 128'b001);
        cyc();
        bus.ch_req_valid   = 3'b000;
        bus.ch_rtn_ready   = 3'b011;
        bus.pipe_rtn_valid = 1'b1;
        bus.pipe_rtn_data  = 128'h1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            #1;
            chk("hol_stall_rtn", 128'(bus.ch_rtn_valid), 128'b100);
            chk("hol_stall_ready", 128'(bus.pipe_rtn_ready), 128'd0);
            chk("hol_stall_cnt", 128'(cnt), 128'd2);
        end
        cyc();
        bus.ch_rtn_ready = 3'b111;
        #1;
        chk("hol_ch2_rtn", 128'(bus.ch_rtn_valid), 128'b100);
        chk("hol_ch2_ready", 128'(bus.pipe_rtn_ready), 128'd1);
        cyc();
        bus.pipe_rtn_data = 128'hA5;
        #1;
        chk("hol_ch0_rtn", 128'(bus.ch_rtn_valid), 128'b001);
        chk("hol_ch0_data", bus.ch_rtn_data[0], 128'hA5);
        cyc();
        bus.pipe_rtn_valid = 1'b0;
        #1;
        chk("hol_drained_cnt", 128'(cnt), 128'd0);

        // Stray return with nothing outstanding.
        bus.pipe_rtn_valid = 1'b1;
        bus.pipe_rtn_data  = 128'h77;
        #1;
        chk("err_no_rtn_valid", 128'(bus.ch_rtn_valid), 128'd0);
        chk("err_drop_ready", 128'(bus.pipe_rtn_ready), 128'd1);
        chk("err_before_edge", 128'(err), 128'd0);
        cyc();
        bus.pipe_rtn_valid = 1'b0;
        #1;
        chk("err_set", 128'(err), 128'd1);
        chk("err_cnt", 128'(cnt), 128'd0);
        cyc();
        #1;
        chk("err_sticky", 128'(err), 128'd1);

        // Three ch1 requests in flight plus a lock on ch1, then reset mid-cycle.
        bus.ch_req_valid      = 3'b010;
        bus.pipe_req_allow_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            #1;
            chk("pre_rst_fire", 128'(bus.ch_req_allow_in), 128'b010);
        end
        cyc();
        bus.pipe_req_allow_in = 1'b0;
        #1;
        chk("pre_rst_stall", 128'(bus.pipe_req_valid), 128'd1);
        cyc();
        bus.ch_req_valid = 3'b111;
        #1;
        chk("pre_rst_locked_chid", 128'(bus.pipe_req_chid), 128'd1);
        chk("pre_rst_cnt", 128'(cnt), 128'd3);
        bus.pipe_req_allow_in = 1'b1;
        bus.pipe_rtn_valid    = 1'b1;
        rst                   = 1'b0;
        #1;
        chk("async_rst_pipe_valid", 128'(bus.pipe_req_valid), 128'd0);
        chk("async_rst_allow_in", 128'(bus.ch_req_allow_in), 128'd0);
        chk("async_rst_rtn_valid", 128'(bus.ch_rtn_valid), 128'd0);
        chk("async_rst_cnt", 128'(cnt), 128'd0);
        chk("async_rst_err", 128'(err), 128'd0);
        cyc();
        rst                = 1'b1;
        bus.pipe_rtn_valid = 1'b0;
        #1;
        chk("post_rst_chid", 128'(bus.pipe_req_chid), 128'd0);
        chk("post_rst_allow_in", 128'(bus.ch_req_allow_in), 128'b001);
        chk("post_rst_cnt", 128'(cnt), 128'd0);
        chk("post_rst_err", 128'(err), 128'd0);
        cyc();
        bus.ch_req_valid = 3'b000;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
